// File: rtl/proc_controller_if.sv
// ---------------------------------------------------------------------------
// proc_controller_if
// Bundles the control unit's ROM, register-file, ALU and data-memory signals.
//   Instr       16  instruction word returned by the ROM
//   PC_Addr      7  ROM address (current PC)
//   D_Addr       8  data memory address
//   D_Wr         1  data memory write enable
//   RF_s         1  RF write-data select (1 = data memory, 0 = ALU)
//   RF_W_addr    4  RF write address
//   RF_W_en      1  RF write enable
//   RF_Ra_addr   4  RF read port A address
//   RF_Rb_addr   4  RF read port B address
//   ALU_s0       3  ALU function (000 pass A, 001 add, 010 subtract)
//   Halted       1  high while halted
//   State        4  current state encoding (debug)
// master: the controller.  slave: ROM / datapath side.
// ---------------------------------------------------------------------------
interface proc_controller_if;
    logic [15:0] Instr;
    logic [6:0]  PC_Addr;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic        Halted;
    logic [3:0]  State;

    modport master (
        input  Instr,
        output PC_Addr, D_Addr, D_Wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted, State
    );

    modport slave (
        output Instr,
        input  PC_Addr, D_Addr, D_Wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted, State
    );
endinterface

// File: rtl/proc_controller.sv
// ---------------------------------------------------------------------------
// proc_controller
// Control unit of the ProjectB processor. Owns the PC addressing the
// instruction ROM, latches the returned instruction into IR and sequences
// the register file, ALU and data memory through a Moore state machine
// (fetch / decode / execute) until HALT or reset.
// Ports:
//   Clk    system clock, rising edge
//   Reset  synchronous, active-high reset
//   bus    proc_controller_if.master (ROM, RF, ALU, data memory, debug)
// Parameter:
//   IM_LAT clock edges from PC_Addr sampled by ROM to valid Instr (1..3)
// ---------------------------------------------------------------------------
module proc_controller #(
    parameter int IM_LAT = 2
) (
    input  logic Clk,
    input  logic Reset,
    proc_controller_if.master bus
);
    localparam logic [3:0] ST_INIT   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_NOOP   = 4'd3;
    localparam logic [3:0] ST_LOADA  = 4'd4;
    localparam logic [3:0] ST_LOADB  = 4'd5;
    localparam logic [3:0] ST_STORE  = 4'd6;
    localparam logic [3:0] ST_ADD    = 4'd7;
    localparam logic [3:0] ST_SUB    = 4'd8;
    localparam logic [3:0] ST_HALT   = 4'd9;

    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    // Fetch lasts IM_LAT+1 cycles: wait counter runs 0..IM_LAT.
    localparam logic [1:0] WAIT_LAST = 2'(IM_LAT);

    logic [3:0]  state_reg;
    logic [3:0]  state_next;
    logic [6:0]  pc_reg;
    logic [15:0] ir_reg;
    logic [1:0]  wait_reg;
    logic        fetch_done;

    assign fetch_done = (state_reg == ST_FETCH) && (wait_reg == WAIT_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= ST_INIT;
            pc_reg    <= 7'd0;
            ir_reg    <= 16'd0;
            wait_reg  <= 2'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_FETCH) begin
                if (fetch_done) begin
                    // Instr is only looked at on this edge; PC wraps 127 -> 0.
                    wait_reg <= 2'd0;
                    ir_reg   <= bus.Instr;
                    pc_reg   <= pc_reg + 7'd1;
                end else begin
                    wait_reg <= wait_reg + 2'd1;
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT:   state_next = ST_FETCH;
            ST_FETCH:  state_next = fetch_done ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (ir_reg[15:12])
                    OP_STORE: state_next = ST_STORE;
                    OP_LOAD:  state_next = ST_LOADA;
                    OP_ADD:   state_next = ST_ADD;
                    OP_SUB:   state_next = ST_SUB;
                    OP_HALT:  state_next = ST_HALT;
                    default:  state_next = ST_NOOP;
                endcase
            end
            ST_NOOP, ST_LOADB, ST_STORE, ST_ADD, ST_SUB: state_next = ST_FETCH;
            ST_LOADA:  state_next = ST_LOADB;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_INIT;
        endcase
    end

    // Moore outputs: functions of state_reg and ir_reg only.
    always_comb begin
        bus.D_Addr     = 8'd0;
        bus.D_Wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = 4'd0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_addr = 4'd0;
        bus.RF_Rb_addr = 4'd0;
        bus.ALU_s0     = 3'b000;
        bus.Halted     = 1'b0;
        case (state_reg)
            ST_STORE: begin
                bus.D_Addr     = ir_reg[7:0];
                bus.RF_Ra_addr = ir_reg[11:8];
                bus.D_Wr       = 1'b1;
            end
            ST_LOADA, ST_LOADB: begin
                // LoadA gives the synchronous data memory a cycle to read;
                // the register write happens only in LoadB.
                bus.D_Addr    = ir_reg[11:4];
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = ir_reg[3:0];
                bus.RF_W_en   = (state_reg == ST_LOADB);
            end
            ST_ADD, ST_SUB: begin
                bus.RF_Ra_addr = ir_reg[11:8];
                bus.RF_Rb_addr = ir_reg[7:4];
                bus.RF_W_addr  = ir_reg[3:0];
                bus.ALU_s0     = (state_reg == ST_ADD) ? 3'b001 : 3'b010;
                bus.RF_W_en    = 1'b1;
            end
            ST_HALT: bus.Halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.PC_Addr = pc_reg;
    assign bus.State   = state_reg;
endmodule

// File: tb/tb_proc_controller.sv
module tb_proc_controller;
    localparam int IM_LAT = 2;

    typedef struct packed {
        logic [3:0] state;
        logic [6:0] pc;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
        logic       halted;
    } obs_t;

    logic Clk;
    logic Reset;
    proc_controller_if bus();

    proc_controller #(.IM_LAT(IM_LAT)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // ROM with registered output: IM_LAT edges from address to data.
    logic [15:0] rom [128];
    logic [15:0] pipe [IM_LAT];
    always @(posedge Clk) begin
        pipe[0] <= rom[bus.PC_Addr];
        for (int i = 1; i < IM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.Instr = pipe[IM_LAT-1];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wen_cnt = 0;
    int wr_cnt = 0;
    logic [3:0] prev_state = 4'd0;
    obs_t sb[$];

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        prev_state <= bus.State;
    end
    always @(negedge Clk) begin
        if (bus.RF_W_en === 1'b1) wen_cnt++;
        if (bus.D_Wr === 1'b1) wr_cnt++;
    end

    function automatic obs_t sample();
        obs_t o;
        o.state  = bus.State;
        o.pc     = bus.PC_Addr;
        o.d_addr = bus.D_Addr;
        o.d_wr   = bus.D_Wr;
        o.rf_s   = bus.RF_s;
        o.w_addr = bus.RF_W_addr;
        o.w_en   = bus.RF_W_en;
        o.ra     = bus.RF_Ra_addr;
        o.rb     = bus.RF_Rb_addr;
        o.alu    = bus.ALU_s0;
        o.halted = bus.Halted;
        return o;
    endfunction

    function automatic obs_t mk(input logic [3:0] st, input logic [6:0] pc,
                                input logic [7:0] da, input logic dw, input logic rs,
                                input logic [3:0] wa, input logic we, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [2:0] alu, input logic h);
        obs_t o;
        o = '{state: st, pc: pc, d_addr: da, d_wr: dw, rf_s: rs, w_addr: wa,
              w_en: we, ra: ra, rb: rb, alu: alu, halted: h};
        return o;
    endfunction

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        while (bus.State !== s && n < budget) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (bus.State !== s) begin
            errors++;
            $display("FAIL %s timeout: state=%0d required=%0d", name, bus.State, s);
        end
    endtask

    task automatic wait_fetch_entry(input int budget, input string name);
        int n = 0;
        while (!(bus.State === 4'd1 && prev_state !== 4'd1) && n < budget) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (!(bus.State === 4'd1 && prev_state !== 4'd1)) begin
            errors++;
            $display("FAIL %s fetch-entry timeout: state=%0d required=1", name, bus.State);
        end
    endtask

    // Pop the expected execute-state observation and compare it now.
    task automatic pop_compare(input string name);
        obs_t got, want;
        got = sample();
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty, actual=%h", name, got);
        end else begin
            want = sb.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL %s actual=%h required=%h", name, got, want);
            end else begin
                $display("txn %-6s state=%0d pc=%0d ok", name, got.state, got.pc);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        wen_cnt = 0;
        wr_cnt = 0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        int cyc0;
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        Reset = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if (bus.State !== 4'd0 || bus.PC_Addr !== 7'd0 || bus.RF_W_en !== 1'b0
                || bus.D_Wr !== 1'b0 || bus.ALU_s0 !== 3'b000 || bus.Halted !== 1'b0) begin
                errors++;
                $display("FAIL reset_state actual state=%0d pc=%0d wen=%b dwr=%b alu=%b halted=%b required 0",
                         bus.State, bus.PC_Addr, bus.RF_W_en, bus.D_Wr, bus.ALU_s0, bus.Halted);
            end
        end
        wen_cnt = 0;
        wr_cnt = 0;
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (bus.State !== 4'd1) begin
            errors++;
            $display("FAIL fetch_after_release actual=%0d required=1", bus.State);
        end
        cyc0 = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_fetch_entry(20, "noop_stream");
            checks++;
            if (bus.PC_Addr !== 7'(k) || (cyc - cyc0) !== 5 * k) begin
                errors++;
                $display("FAIL noop_cpi actual pc=%0d dt=%0d required pc=%0d dt=%0d",
                         bus.PC_Addr, cyc - cyc0, k, 5 * k);
            end
            $display("txn noop   pc=%0d at +%0d", bus.PC_Addr, cyc - cyc0);
            @(negedge Clk);
        end
        checks++;
        if (wen_cnt !== 0 || wr_cnt !== 0) begin
            errors++;
            $display("FAIL noop_enables actual wen=%0d dwr=%0d required 0 0", wen_cnt, wr_cnt);
        end
    endtask

    task automatic test_program();
        int cyc0;
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h2A53;
        rom[1] = 16'h3127;
        rom[2] = 16'h4456;
        rom[3] = 16'h163C;
        rom[4] = 16'h5000;
        rom[5] = 16'h3127;
        // Expected execute-cycle outputs, in program order.
        sb.push_back(mk(4'd4, 7'd1, 8'hA5, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0));
        sb.push_back(mk(4'd5, 7'd1, 8'hA5, 1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 4'd0, 3'b000, 1'b0));
        sb.push_back(mk(4'd7, 7'd2, 8'h00, 1'b0, 1'b0, 4'd7, 1'b1, 4'd1, 4'd2, 3'b001, 1'b0));
        sb.push_back(mk(4'd8, 7'd3, 8'h00, 1'b0, 1'b0, 4'd6, 1'b1, 4'd4, 4'd5, 3'b010, 1'b0));
        sb.push_back(mk(4'd6, 7'd4, 8'h3C, 1'b1, 1'b0, 4'd0, 1'b0, 4'd6, 4'd0, 3'b000, 1'b0));
        sb.push_back(mk(4'd9, 7'd5, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b1));
        do_reset();
        wait_fetch_entry(20, "prog_start");
        cyc0 = cyc;
        wait_state(4'd4, 20, "load_a");
        pop_compare("loada");
        @(negedge Clk);
        pop_compare("loadb");
        wait_fetch_entry(20, "after_load");
        checks++;
        if ((cyc - cyc0) !== 6 || bus.PC_Addr !== 7'd1) begin
            errors++;
            $display("FAIL load_cpi actual dt=%0d pc=%0d required dt=6 pc=1", cyc - cyc0, bus.PC_Addr);
        end
        wait_state(4'd7, 20, "add");
        pop_compare("add");
        wait_state(4'd8, 20, "sub");
        pop_compare("sub");
        wait_state(4'd6, 20, "store");
        pop_compare("store");
        wait_state(4'd9, 20, "halt");
        pop_compare("halt");
        repeat (30) @(negedge Clk);
        checks++;
        if (bus.Halted !== 1'b1 || bus.PC_Addr !== 7'd5 || bus.State !== 4'd9) begin
            errors++;
            $display("FAIL halt_hold actual halted=%b pc=%0d state=%0d required 1 5 9",
                     bus.Halted, bus.PC_Addr, bus.State);
        end
        checks++;
        if (wen_cnt !== 3 || wr_cnt !== 1) begin
            errors++;
            $display("FAIL pulse_count actual wen=%0d dwr=%0d required 3 1", wen_cnt, wr_cnt);
        end
        do_reset();
        checks++;
        if (bus.State !== 4'd1 || bus.PC_Addr !== 7'd0 || bus.Halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_restart actual state=%0d pc=%0d halted=%b required 1 0 0",
                     bus.State, bus.PC_Addr, bus.Halted);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        do_reset();
        for (int k = 0; k <= 128; k++) begin
            wait_fetch_entry(20, "wrap");
            checks++;
            if (bus.PC_Addr !== 7'(k & 127)) begin
                errors++;
                $display("FAIL pc_wrap actual=%0d required=%0d", bus.PC_Addr, k & 127);
            end
            @(negedge Clk);
        end
        $display("txn wrap   pc reached %0d after 128 noops", bus.PC_Addr);
        checks++;
        if (wen_cnt !== 0 || wr_cnt !== 0) begin
            errors++;
            $display("FAIL wrap_enables actual wen=%0d dwr=%0d required 0 0", wen_cnt, wr_cnt);
        end
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h2A53;
        do_reset();
        wait_state(4'd4, 20, "mid_load");
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if (bus.State !== 4'd0 || bus.PC_Addr !== 7'd0 || bus.RF_W_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_load_reset actual state=%0d pc=%0d wen=%b required 0 0 0",
                     bus.State, bus.PC_Addr, bus.RF_W_en);
        end
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (wen_cnt !== 0 || bus.State !== 4'd1) begin
            errors++;
            $display("FAIL mid_load_abort actual wen=%0d state=%0d required 0 1", wen_cnt, bus.State);
        end
        $display("txn abort  load aborted by reset");
    endtask

    initial begin
        Reset = 1'b1;
        test_reset();
        test_program();
        test_wrap();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
